// File: rtl/alu_pkg.sv
// Shared types and constants for the RV32I integer ALU.
package alu_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  // Operation select; encodings match the aluop field driven by the decoder.
  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops_t;

  // Barrel shifter controls derived from the opcode.
  typedef struct packed {
    logic left;   // 1: shift toward MSB, zero fill
    logic arith;  // 1: right shift fills with the operand sign bit
  } shift_ctrl_t;

  // Map an opcode to shifter controls; non-shift opcodes yield a don't-care
  // right logical shift whose result the result mux never selects.
  function automatic shift_ctrl_t shift_ctrl(input alu_ops_t op);
    shift_ctrl_t c;
    c.left  = (op == alu_sll);
    c.arith = (op == alu_sra);
    return c;
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Combinational 32-bit barrel shifter: five stages of 1/2/4/8/16 bit
// positions, each stage either passing its input or shifting it.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0]  a,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               left,
  input  logic               arith,
  output logic [DATA_W-1:0]  y
);

  logic              fill;
  logic [DATA_W-1:0] s0, s1, s2, s3, s4, s5;

  // One shifter stage by a fixed distance k. Right shifts pull fill bits in
  // from a sign-extended upper half so sra and srl share the same datapath.
  function automatic logic [DATA_W-1:0] stage(
    input logic [DATA_W-1:0] d,
    input logic              en,
    input logic              to_left,
    input logic              fill_bit,
    input int unsigned       k
  );
    logic [2*DATA_W-1:0] ext;
    logic [DATA_W-1:0]   res;
    ext = {{DATA_W{fill_bit}}, d} >> k;
    if (!en)         res = d;
    else if (to_left) res = d << k;
    else             res = ext[DATA_W-1:0];
    return res;
  endfunction

  // Sign fill applies only to arithmetic right shifts.
  assign fill = arith & ~left & a[DATA_W-1];

  assign s0 = a;
  assign s1 = stage(s0, shamt[0], left, fill, 1);
  assign s2 = stage(s1, shamt[1], left, fill, 2);
  assign s3 = stage(s2, shamt[2], left, fill, 4);
  assign s4 = stage(s3, shamt[3], left, fill, 8);
  assign s5 = stage(s4, shamt[4], left, fill, 16);
  assign y  = s5;

endmodule

// File: rtl/alu.sv
// Registered RV32I integer ALU: add/sub on a shared adder, logic ops,
// barrel shifts, one result register updated every cycle.
module alu
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  aluop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] f
);

  alu_ops_t          op;
  shift_ctrl_t       sctl;
  logic              is_sub;
  logic [DATA_W-1:0] b_add;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] result;

  assign op   = alu_ops_t'(aluop);
  assign sctl = shift_ctrl(op);

  // Subtraction reuses the adder as a + ~b + 1; carry-out is discarded so
  // both operations wrap modulo 2^32.
  assign is_sub = (op == alu_sub);
  assign b_add  = is_sub ? ~b : b;
  assign sum    = a + b_add + {{(DATA_W-1){1'b0}}, is_sub};

  // Only the low five bits of b form the shift amount.
  alu_shifter u_shifter (
    .a     (a),
    .shamt (b[SHAMT_W-1:0]),
    .left  (sctl.left),
    .arith (sctl.arith),
    .y     (shifted)
  );

  // Result select for the current opcode.
  always_comb begin
    // NOTE: default assignment first so no path leaves result unassigned (no latch).
    result = '0;
    unique case (op)
      alu_add, alu_sub:          result = sum;
      alu_sll, alu_sra, alu_srl: result = shifted;
      alu_xor:                   result = a ^ b;
      alu_or:                    result = a | b;
      alu_and:                   result = a & b;
      default:                   result = '0;
    endcase
  end

  // Output register; reset clears it immediately and discards in-flight work.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignment for registered state avoids simulation races.
    if (!rst_n) f <= '0;
    else        f <= result;
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: vector table plus reset, latency and X sequences.
module tb_alu;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [2:0]  aluop;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] f;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .aluop (aluop),
    .a     (a),
    .b     (b),
    .f     (f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb);
    aluop = op;
    a     = va;
    b     = vb;
  endtask

  logic [31:0] lat_exp [8];

  initial begin
    // Sweep, wrap, shift-bound and a few extra patterns, all hand-computed.
    vecs.push_back('{"sweep_add", 3'd0, 32'h800055AA, 32'h00000004, 32'h800055AE});
    vecs.push_back('{"sweep_sll", 3'd1, 32'h800055AA, 32'h00000004, 32'h00055AA0});
    vecs.push_back('{"sweep_sra", 3'd2, 32'h800055AA, 32'h00000004, 32'hF800055A});
    vecs.push_back('{"sweep_sub", 3'd3, 32'h800055AA, 32'h00000004, 32'h800055A6});
    vecs.push_back('{"sweep_xor", 3'd4, 32'h800055AA, 32'h00000004, 32'h800055AE});
    vecs.push_back('{"sweep_srl", 3'd5, 32'h800055AA, 32'h00000004, 32'h0800055A});
    vecs.push_back('{"sweep_or",  3'd6, 32'h800055AA, 32'h00000004, 32'h800055AE});
    vecs.push_back('{"sweep_and", 3'd7, 32'h800055AA, 32'h00000004, 32'h00000000});
    vecs.push_back('{"add_wrap",  3'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000});
    vecs.push_back('{"sub_wrap",  3'd3, 32'h00000000, 32'h00000001, 32'hFFFFFFFF});
    vecs.push_back('{"sra_31",    3'd2, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF});
    vecs.push_back('{"srl_31",    3'd5, 32'h80000000, 32'h0000001F, 32'h00000001});
    vecs.push_back('{"sll_amt0",  3'd1, 32'h00000001, 32'hFFFFFFE0, 32'h00000001});
    vecs.push_back('{"sll_31",    3'd1, 32'h00000001, 32'h0000001F, 32'h80000000});
    vecs.push_back('{"sra_pos",   3'd2, 32'h7FFFFFFF, 32'h00000004, 32'h07FFFFFF});
    vecs.push_back('{"srl_hi_b",  3'd5, 32'hFFFFFFFF, 32'h00000021, 32'h7FFFFFFF});
    vecs.push_back('{"sub_neg",   3'd3, 32'h00000005, 32'h00000007, 32'hFFFFFFFE});
    vecs.push_back('{"add_ovf",   3'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000});
    vecs.push_back('{"or_mix",    3'd6, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0});
    vecs.push_back('{"xor_mix",   3'd4, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F});
    vecs.push_back('{"and_mix",   3'd7, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00});

    // a = 0x0F0F00FF, b = 0x00000008 for ops 0..7.
    lat_exp[0] = 32'h0F0F0107;
    lat_exp[1] = 32'h0F00FF00;
    lat_exp[2] = 32'h000F0F00;
    lat_exp[3] = 32'h0F0F00F7;
    lat_exp[4] = 32'h0F0F00F7;
    lat_exp[5] = 32'h000F0F00;
    lat_exp[6] = 32'h0F0F00FF;
    lat_exp[7] = 32'h00000008;

    // Reset held with random inputs while the clock runs.
    rst_n = 1'b0;
    drive(3'($urandom_range(0, 7)), $urandom, $urandom);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_hold", f, 32'h0);
      drive(3'($urandom_range(0, 7)), $urandom, $urandom);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors: drive after an edge, check one edge later.
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      @(posedge clk);
      #1;
      check(vecs[i].name, f, vecs[i].exp);
    end

    // Back-to-back opcode changes: f holds the previous result until the
    // next edge, then shows the new one.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      drive(3'(7 - k), 32'h0F0F00FF, 32'h00000008);
      #3;
      if (k > 0) check("lat_hold", f, lat_exp[8 - k]);
      @(posedge clk);
      #1;
      check("lat_next", f, lat_exp[7 - k]);
    end

    // Mid-stream reset clears f without a clock edge.
    @(negedge clk);
    drive(3'd0, 32'h00001000, 32'h00000234);
    @(posedge clk);
    #1;
    check("pre_reset", f, 32'h00001234);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", f, 32'h0);
    @(posedge clk);
    #1;
    check("reset_discard", f, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Unknown inputs for two cycles, then known values recover f.
    @(negedge clk);
    aluop = 'x;
    a     = 'x;
    b     = 'x;
    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(3'd0, 32'h00000003, 32'h00000004);
    @(posedge clk);
    #1;
    check("x_recover", f, 32'h00000007);
    @(negedge clk);
    drive(3'd3, 32'h00000003, 32'h00000004);
    @(posedge clk);
    #1;
    check("x_recover_sub", f, 32'hFFFFFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
